// File: rtl/pixel_write_arbiter.sv
// rtl/pixel_write_arbiter.sv - round-robin burst arbiter for the shared VGA pixel-write port
// Grants one draw engine at a time, registers its pixels and clips off-screen writes.
module pixel_write_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int X_W       = 8,
  parameter int Y_W       = 8,
  parameter int COLOR_W   = 3,
  parameter int X_MAX     = 239,
  parameter int Y_MAX     = 179,
  parameter int MAX_BURST = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         last,
  input  logic [NUM_REQ*X_W-1:0]     x_in,
  input  logic [NUM_REQ*Y_W-1:0]     y_in,
  input  logic [NUM_REQ*COLOR_W-1:0] colour_in,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         accept,
  output logic [X_W-1:0]             vga_x,
  output logic [Y_W-1:0]             vga_y,
  output logic [COLOR_W-1:0]         vga_colour,
  output logic                       vga_plot,
  output logic [15:0]                clip_count,
  output logic                       busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST);
  localparam logic [X_W-1:0] X_LIM    = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM    = Y_W'(Y_MAX);
  localparam logic [BW-1:0]  BURST_END = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t               state, state_next;
  logic [PW-1:0]        ptr, owner, pick, cand;
  logic [BW-1:0]        burst_cnt;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic                 found, any_req, owner_req, owner_last, owner_acc, rel, on_screen;
  logic [X_W-1:0]       owner_x;
  logic [Y_W-1:0]       owner_y;
  logic [COLOR_W-1:0]   owner_colour;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  assign accept       = grant & req;
  assign any_req      = |req;
  assign owner_req    = req[owner];
  assign owner_last   = last[owner];
  assign owner_acc    = accept[owner];
  assign owner_x      = x_in[owner*X_W +: X_W];
  assign owner_y      = y_in[owner*Y_W +: Y_W];
  assign owner_colour = colour_in[owner*COLOR_W +: COLOR_W];
  assign on_screen    = (owner_x <= X_LIM) && (owner_y <= Y_LIM);
  assign busy         = (state == OWN);

  // Release when the engine withdraws, finishes its shape, or exhausts its burst.
  assign rel = !owner_req || (owner_acc && (owner_last || burst_cnt == BURST_END));

  // First requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = wrap_add(ptr, i);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    pick_onehot       = '0;
    pick_onehot[pick] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = OWN;
      OWN:     if (rel)     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      grant     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= pick;
            grant     <= pick_onehot;
            burst_cnt <= '0;
          end
        end
        OWN: begin
          if (owner_acc) burst_cnt <= burst_cnt + 1'b1;
          if (rel) begin
            grant <= '0;
            ptr   <= wrap_add(owner, 1);
          end
        end
        default: grant <= '0;
      endcase
    end
  end

  // Pixel registers; coordinates are captured even for clipped pixels.
  always_ff @(posedge clock) begin
    if (reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      clip_count <= '0;
    end else begin
      vga_plot <= 1'b0;
      if (owner_acc) begin
        vga_x      <= owner_x;
        vga_y      <= owner_y;
        vga_colour <= owner_colour;
        if (on_screen) vga_plot <= 1'b1;
        else if (clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb/tb_pixel_write_arbiter.sv - directed self-checking bench for pixel_write_arbiter
// Each engine replays a pixel list and advances whenever its accept was high before the edge.
module tb_pixel_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req, last;
  logic [7:0]  xs [3];
  logic [7:0]  ys [3];
  logic [2:0]  cs [3];
  logic [23:0] x_in, y_in;
  logic [8:0]  colour_in;
  logic [2:0]  grant, accept;
  logic [7:0]  vga_x, vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy;
  logic [15:0] clip_count;

  logic [7:0]  px [3][32];
  logic [7:0]  py [3][32];
  logic [2:0]  pc [3][32];
  logic        pl [3][32];
  int          n_pix [3];
  int          idx [3];
  logic [2:0]  acc_s;
  int          n_checks = 0;
  int          n_fail = 0;

  assign x_in      = {xs[2], xs[1], xs[0]};
  assign y_in      = {ys[2], ys[1], ys[0]};
  assign colour_in = {cs[2], cs[1], cs[0]};

  always #5 clock = ~clock;

  pixel_write_arbiter dut (
    .clock(clock), .reset(reset), .req(req), .last(last),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .grant(grant), .accept(accept), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .clip_count(clip_count), .busy(busy)
  );

  task automatic drive();
    for (int e = 0; e < 3; e++) begin
      if (idx[e] < n_pix[e]) begin
        req[e]  = 1'b1;
        last[e] = pl[e][idx[e]];
        xs[e]   = px[e][idx[e]];
        ys[e]   = py[e][idx[e]];
        cs[e]   = pc[e][idx[e]];
      end else begin
        req[e]  = 1'b0;
        last[e] = 1'b0;
        xs[e]   = 8'd0;
        ys[e]   = 8'd0;
        cs[e]   = 3'd0;
      end
    end
  endtask

  task automatic clear_engines();
    for (int e = 0; e < 3; e++) begin
      n_pix[e] = 0;
      idx[e]   = 0;
    end
    drive();
  endtask

  task automatic cycle();
    @(negedge clock);
    acc_s = accept;
    @(posedge clock);
    #1;
    for (int e = 0; e < 3; e++) if (acc_s[e]) idx[e]++;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_engines();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant got %b want 000", grant); end
    n_checks++; if (vga_plot !== 1'b0) begin n_fail++; $display("FAIL reset_plot got %b want 0", vga_plot); end
    n_checks++; if (clip_count !== 16'd0) begin n_fail++; $display("FAIL reset_clip got %0d want 0", clip_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if ({vga_x, vga_y, vga_colour} !== 19'd0) begin n_fail++; $display("FAIL reset_pixel got %0d,%0d,%0d want 0,0,0", vga_x, vga_y, vga_colour); end
  endtask

  task automatic test_basic();
    int eg [5] = '{1, 1, 1, 0, 0};
    int ep [5] = '{0, 1, 1, 1, 0};
    int ex [5] = '{0, 0, 1, 2, 0};
    do_reset();
    for (int j = 0; j < 3; j++) begin
      px[0][j] = 8'(j); py[0][j] = 8'd0; pc[0][j] = 3'(j + 1); pl[0][j] = (j == 2);
    end
    n_pix[0] = 3;
    drive();
    #1;
    n_checks++; if (grant !== 3'b000 || accept !== 3'b000) begin n_fail++; $display("FAIL basic_idle grant=%b accept=%b want 000/000", grant, accept); end
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_checks++; if (grant !== 3'(eg[k])) begin n_fail++; $display("FAIL basic_grant cycle %0d got %b want %0d", k + 1, grant, eg[k]); end
      n_checks++; if (vga_plot !== 1'(ep[k])) begin n_fail++; $display("FAIL basic_plot cycle %0d got %b want %0d", k + 1, vga_plot, ep[k]); end
      if (ep[k] == 1) begin
        n_checks++;
        if (vga_x !== 8'(ex[k]) || vga_y !== 8'd0 || vga_colour !== 3'(ex[k] + 1)) begin
          n_fail++; $display("FAIL basic_pixel cycle %0d got %0d,%0d,%0d want %0d,0,%0d", k + 1, vga_x, vga_y, vga_colour, ex[k], ex[k] + 1);
        end
      end
    end
    n_checks++; if (clip_count !== 16'd0) begin n_fail++; $display("FAIL basic_clip got %0d want 0", clip_count); end
  endtask

  task automatic test_round_robin();
    int o;
    do_reset();
    for (int e = 0; e < 3; e++) begin
      for (int j = 0; j < 4; j++) begin
        px[e][j] = 8'(10 * e + j); py[e][j] = 8'(e); pc[e][j] = 3'(e + 1); pl[e][j] = 1'b1;
      end
      n_pix[e] = 4;
    end
    drive();
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (k % 2 == 1) begin
        o = ((k - 1) / 2) % 3;
        n_checks++; if (grant !== 3'(1 << o) || busy !== 1'b1) begin n_fail++; $display("FAIL rr_grant cycle %0d got %b busy %b want %b busy 1", k, grant, busy, 3'(1 << o)); end
        n_checks++; if (vga_plot !== 1'b0) begin n_fail++; $display("FAIL rr_plot_idle cycle %0d got %b want 0", k, vga_plot); end
      end else begin
        o = ((k - 2) / 2) % 3;
        n_checks++; if (grant !== 3'b000 || busy !== 1'b0) begin n_fail++; $display("FAIL rr_release cycle %0d got %b busy %b want 000 busy 0", k, grant, busy); end
        n_checks++;
        if (vga_plot !== 1'b1 || vga_x !== 8'(10 * o + (k - 2) / 6) || vga_y !== 8'(o)) begin
          n_fail++; $display("FAIL rr_pixel cycle %0d got plot %b at %0d,%0d want plot 1 at %0d,%0d", k, vga_plot, vga_x, vga_y, 10 * o + (k - 2) / 6, o);
        end
      end
    end
  endtask

  task automatic test_burst_limit();
    int plots = 0;
    logic ep;
    logic [2:0] eg;
    do_reset();
    for (int j = 0; j < 20; j++) begin
      px[1][j] = 8'(j); py[1][j] = 8'd5; pc[1][j] = 3'(j % 8); pl[1][j] = (j == 19);
    end
    n_pix[1] = 20;
    drive();
    for (int k = 1; k <= 24; k++) begin
      cycle();
      ep = (k >= 2 && k <= 17) || (k >= 19 && k <= 22);
      eg = ((k >= 1 && k <= 16) || (k >= 18 && k <= 21)) ? 3'b010 : 3'b000;
      n_checks++; if (grant !== eg) begin n_fail++; $display("FAIL burst_grant cycle %0d got %b want %b", k, grant, eg); end
      n_checks++; if (vga_plot !== ep) begin n_fail++; $display("FAIL burst_plot cycle %0d got %b want %b", k, vga_plot, ep); end
      if (ep) begin
        n_checks++; if (vga_x !== 8'(plots) || vga_y !== 8'd5) begin n_fail++; $display("FAIL burst_pixel cycle %0d got %0d,%0d want %0d,5", k, vga_x, vga_y, plots); end
      end
      if (vga_plot === 1'b1) plots++;
    end
    n_checks++; if (plots !== 20) begin n_fail++; $display("FAIL burst_total got %0d want 20", plots); end
  endtask

  task automatic test_clipping();
    do_reset();
    px[0][0] = 8'd240; py[0][0] = 8'd10;  pc[0][0] = 3'd1; pl[0][0] = 1'b0;
    px[0][1] = 8'd10;  py[0][1] = 8'd180; pc[0][1] = 3'd2; pl[0][1] = 1'b0;
    px[0][2] = 8'd239; py[0][2] = 8'd179; pc[0][2] = 3'd3; pl[0][2] = 1'b1;
    n_pix[0] = 3;
    drive();
    cycle();
    cycle();
    n_checks++; if (vga_plot !== 1'b0 || vga_x !== 8'd240 || clip_count !== 16'd1) begin n_fail++; $display("FAIL clip_x got plot %b x %0d clip %0d want 0,240,1", vga_plot, vga_x, clip_count); end
    cycle();
    n_checks++; if (vga_plot !== 1'b0 || vga_y !== 8'd180 || clip_count !== 16'd2) begin n_fail++; $display("FAIL clip_y got plot %b y %0d clip %0d want 0,180,2", vga_plot, vga_y, clip_count); end
    cycle();
    n_checks++; if (vga_plot !== 1'b1 || vga_x !== 8'd239 || vga_y !== 8'd179 || clip_count !== 16'd2) begin n_fail++; $display("FAIL clip_edge got plot %b at %0d,%0d clip %0d want 1 at 239,179 clip 2", vga_plot, vga_x, vga_y, clip_count); end
  endtask

  task automatic test_withdraw();
    do_reset();
    for (int j = 0; j < 2; j++) begin
      px[0][j] = 8'(j); py[0][j] = 8'd7; pc[0][j] = 3'd4; pl[0][j] = 1'b0;
    end
    n_pix[0] = 2;
    drive();
    cycle();
    cycle();
    cycle();
    n_checks++; if (grant !== 3'b001 || vga_plot !== 1'b1 || vga_x !== 8'd1) begin n_fail++; $display("FAIL wd_second got grant %b plot %b x %0d want 001,1,1", grant, vga_plot, vga_x); end
    cycle();
    n_checks++; if (grant !== 3'b000 || vga_plot !== 1'b0) begin n_fail++; $display("FAIL wd_release got grant %b plot %b want 000,0", grant, vga_plot); end
    for (int e = 0; e < 2; e++) begin
      idx[e] = 0; n_pix[e] = 1;
      px[e][0] = 8'(70 + 7 * e); py[e][0] = 8'd3; pc[e][0] = 3'd5; pl[e][0] = 1'b1;
    end
    drive();
    cycle();
    n_checks++; if (grant !== 3'b010) begin n_fail++; $display("FAIL wd_ptr_advance got %b want 010", grant); end
    cycle();
    n_checks++; if (vga_plot !== 1'b1 || vga_x !== 8'd77 || grant !== 3'b000) begin n_fail++; $display("FAIL wd_plot1 got plot %b x %0d grant %b want 1,77,000", vga_plot, vga_x, grant); end
    cycle();
    n_checks++; if (grant !== 3'b001) begin n_fail++; $display("FAIL wd_wrap got %b want 001", grant); end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int j = 0; j < 10; j++) begin
      px[0][j] = 8'd250; py[0][j] = 8'(j); pc[0][j] = 3'd6; pl[0][j] = 1'b0;
    end
    n_pix[0] = 10;
    drive();
    for (int k = 1; k <= 5; k++) cycle();
    n_checks++; if (grant !== 3'b001 || clip_count !== 16'd4) begin n_fail++; $display("FAIL rst_pre got grant %b clip %0d want 001,4", grant, clip_count); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++; if (grant !== 3'b000 || vga_plot !== 1'b0 || clip_count !== 16'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid got grant %b plot %b clip %0d busy %b want 000,0,0,0", grant, vga_plot, clip_count, busy); end
    clear_engines();
    px[2][0] = 8'd5; py[2][0] = 8'd5; pc[2][0] = 3'd7; pl[2][0] = 1'b1;
    n_pix[2] = 1;
    drive();
    cycle();
    n_checks++; if (grant !== 3'b100) begin n_fail++; $display("FAIL rst_fresh_grant got %b want 100", grant); end
    cycle();
    n_checks++; if (vga_plot !== 1'b1 || vga_x !== 8'd5 || vga_colour !== 3'd7) begin n_fail++; $display("FAIL rst_fresh_plot got plot %b x %0d colour %0d want 1,5,7", vga_plot, vga_x, vga_colour); end
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    last  = '0;
    test_reset();
    test_basic();
    test_round_robin();
    test_burst_limit();
    test_clipping();
    test_withdraw();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
